ahbl_splitter_n: RTL and testbench

- Parametrised AHB-Lite address decoder and response multiplexer for one master (Hazard2) and NUM_S slaves.
- Successor to the fixed 4-slave splitter:
  - slave count and decode field are generic;
  - a built-in default slave answers unmapped accesses with a two-cycle ERROR response;
  - HRESP is driven to the master.
- Sits between the CPU bus and the PMEM/DMEM/GPIO-splitter slaves in the SoC top.

---
 rtl/ahbl_splitter_n_pkg.sv | 29 ++
 rtl/ahbl_splitter_n_if.sv | 25 ++
 rtl/ahbl_splitter_n_default_slave.sv | 35 +++
 rtl/ahbl_splitter_n.sv | 130 +++++++++++++
 tb/tb_ahbl_splitter_n.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/ahbl_splitter_n_pkg.sv
// Shared AHB-Lite encodings for the splitter, default slave, RAM and GPIO blocks.
package ahbl_pkg;

  // HTRANS encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // HRESP encodings
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Default-slave FSM state encoding
  localparam logic [1:0] DS_IDLE = 2'd0;
  localparam logic [1:0] DS_ERR1 = 2'd1;
  localparam logic [1:0] DS_ERR2 = 2'd2;

  // HSIZE encodings
  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // True for transfers that actually move data (NONSEQ/SEQ)
  function automatic logic htrans_active(input logic [1:0] t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahbl_splitter_n_if.sv
// AHB-Lite master-side bus plus fanned-out slave-side select/response lines.
interface ahbl_splitter_n_if #(
  parameter int NUM_S = 4
);
  logic [31:0]         HADDR;
  logic [1:0]          HTRANS;
  logic                HREADY;
  logic [31:0]         HRDATA;
  logic                HRESP;
  logic [NUM_S-1:0]    S_HSEL;
  logic [NUM_S*32-1:0] S_HRDATA;
  logic [NUM_S-1:0]    S_HREADYOUT;

  // Splitter side
  modport slave (
    input  HADDR, HTRANS, S_HRDATA, S_HREADYOUT,
    output HREADY, HRDATA, HRESP, S_HSEL
  );

  // CPU + slave-array side
  modport master (
    output HADDR, HTRANS, S_HRDATA, S_HREADYOUT,
    input  HREADY, HRDATA, HRESP, S_HSEL
  );
endinterface

// File: rtl/ahbl_splitter_n_default_slave.sv
// AHB-Lite default slave: answers a started transfer with a two-cycle ERROR.
module ahbl_default_slave
  import ahbl_pkg::*;
(
  input  logic HCLK,
  input  logic HRESET,
  input  logic start,
  input  logic HREADY,
  output logic ready_o,
  output logic resp_o
);

  logic [1:0] state_q, state_d;

  // Next state: ERR1 always moves on, start is only sampled on an accepted address phase
  always_comb begin
    state_d = state_q;
    case (state_q)
      DS_IDLE: if (HREADY && start) state_d = DS_ERR1;
      DS_ERR1: state_d = DS_ERR2;
      DS_ERR2: state_d = (HREADY && start) ? DS_ERR1 : DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state_q <= DS_IDLE;
    else        state_q <= state_d;
  end

  assign ready_o = (state_q != DS_ERR1);
  assign resp_o  = (state_q == DS_ERR1) || (state_q == DS_ERR2) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: rtl/ahbl_splitter_n.sv
// Parametrised AHB-Lite decoder / response mux, one master to NUM_S slaves,
// with a built-in default slave for unmapped space.
// Optional: define AHBL_TIMEOUT_EN to bound slave wait states and mask hung slaves.
module ahbl_splitter_n
  import ahbl_pkg::*;
#(
  parameter int                     NUM_S       = 4,
  parameter int                     DEC_MSB     = 31,
  parameter int                     DEC_W       = 4,
  parameter logic [NUM_S*DEC_W-1:0] S_BASE      = {4'h8, 4'h4, 4'h2, 4'h0},
  parameter int                     TIMEOUT_CYC = 255
) (
  input  logic              HCLK,
  input  logic              HRESET,
  ahbl_splitter_n_if.slave  bus,
  output logic [NUM_S-1:0]  TIMEOUT_MASK
);

  // Entry NUM_S of the data-phase select is the default slave
  localparam logic [NUM_S:0] DEF_SEL = {1'b1, {NUM_S{1'b0}}};

  logic [DEC_W-1:0]       dec_field;
  logic [NUM_S-1:0]       match, hsel, masked;
  logic                   unmapped;
  logic [NUM_S:0]         dsel_q, dsel_d;
  logic                   to_hit;
  logic                   ds_start, ds_hready, ds_ready, ds_resp;
  logic [NUM_S-1:0][31:0] rd_term;
  logic [NUM_S-1:0]       rdy_term;
  logic [31:0]            rdata;
  logic                   unused_haddr;

  assign dec_field    = bus.HADDR[DEC_MSB -: DEC_W];
  assign unused_haddr = ^bus.HADDR;

  // Per-slave address match and data-phase response terms
  genvar gi;
  generate
    for (gi = 0; gi < NUM_S; gi++) begin : g_slv
      assign match[gi]    = (dec_field == S_BASE[gi*DEC_W +: DEC_W]);
      assign rd_term[gi]  = dsel_q[gi] ? bus.S_HRDATA[gi*32 +: 32] : 32'h0;
      assign rdy_term[gi] = dsel_q[gi] & bus.S_HREADYOUT[gi];
    end
  endgenerate

  // Lowest matching index owns the address; a masked owner falls to the default slave
  always_comb begin : prio
    logic taken;
    taken = 1'b0;
    hsel  = '0;
    for (int i = 0; i < NUM_S; i++) begin
      hsel[i] = match[i] & ~taken & ~masked[i];
      taken   = taken | match[i];
    end
  end

  assign unmapped   = ~|hsel;
  assign bus.S_HSEL = hsel;

`ifdef AHBL_TIMEOUT_EN
  logic [15:0]      cnt_q, cnt_d;
  logic [NUM_S-1:0] mask_q, mask_d;
  logic             stall;

  // A real slave owns the data phase and is holding the bus
  assign stall  = ~dsel_q[NUM_S] & ~bus.HREADY;
  assign to_hit = stall & (cnt_q == 16'(TIMEOUT_CYC - 1));

  // Count consecutive stalled cycles; any ready or ownership change restarts it
  always_comb begin
    cnt_d  = (stall && !to_hit) ? cnt_q + 16'd1 : 16'd0;
    mask_d = mask_q | (to_hit ? dsel_q[NUM_S-1:0] : '0);
  end

  // Timeout counter and sticky hung-slave mask
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      cnt_q  <= '0;
      mask_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      mask_q <= mask_d;
    end
  end

  assign masked = mask_q;
`else
  assign to_hit = 1'b0;
  assign masked = '0;
`endif

  assign TIMEOUT_MASK = masked;

  // Data-phase owner: follows the address phase on HREADY, seized by the default slave on timeout
  always_comb begin
    dsel_d = dsel_q;
    if (to_hit)          dsel_d = DEF_SEL;
    else if (bus.HREADY) dsel_d = {unmapped, hsel};
  end

  // Data-phase select register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) dsel_q <= DEF_SEL;
    else        dsel_q <= dsel_d;
  end

  // A timeout injects a forced start into the default slave while the bus is stalled
  assign ds_start  = (htrans_active(bus.HTRANS) & unmapped) | to_hit;
  assign ds_hready = bus.HREADY | to_hit;

  ahbl_default_slave u_def (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .start   (ds_start),
    .HREADY  (ds_hready),
    .ready_o (ds_ready),
    .resp_o  (ds_resp)
  );

  // OR-reduce the one-hot gated read data
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_S; i++) rdata = rdata | rd_term[i];
  end

  assign bus.HRDATA = rdata;
  assign bus.HREADY = dsel_q[NUM_S] ? ds_ready : |rdy_term;
  assign bus.HRESP  = dsel_q[NUM_S] ? ds_resp  : HRESP_OKAY;

endmodule

// File: tb/tb_ahbl_splitter_n.sv
// Directed self-checking bench for ahbl_splitter_n (NUM_S=4, TIMEOUT_CYC=8).
module tb_ahbl_splitter_n;
  import ahbl_pkg::*;

  logic       HCLK;
  logic       HRESET;
  logic [3:0] TIMEOUT_MASK;
  int         total = 0;
  int         bad   = 0;

  ahbl_splitter_n_if #(.NUM_S(4)) bus ();

  ahbl_splitter_n #(.NUM_S(4), .TIMEOUT_CYC(8)) dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .bus          (bus),
    .TIMEOUT_MASK (TIMEOUT_MASK)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #2;
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] t);
    bus.HADDR  = a;
    bus.HTRANS = t;
    #1;
  endtask

  initial begin
    HRESET          = 1'b1;
    bus.HADDR       = 32'h0;
    bus.HTRANS      = HTRANS_IDLE;
    bus.S_HREADYOUT = 4'b1111;
    bus.S_HRDATA    = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_1111};
    step();
    #1;
    chk("rst_hready", {31'd0, bus.HREADY}, 32'd1);
    chk("rst_hresp",  {31'd0, bus.HRESP},  32'd0);
    chk("rst_hrdata", bus.HRDATA, 32'h0);
    chk("rst_tmask",  {28'd0, TIMEOUT_MASK}, 32'd0);
    chk("rst_hsel",   {28'd0, bus.S_HSEL}, 32'b0001);
    step();
    HRESET = 1'b0;
    step();

    // Slave1 read with one wait state
    drive(32'h2000_0010, HTRANS_NONSEQ);
    chk("s1_hsel", {28'd0, bus.S_HSEL}, 32'b0010);
    step();
    bus.S_HREADYOUT = 4'b1101;
    drive(32'h0, HTRANS_IDLE);
    chk("s1_wait_hready", {31'd0, bus.HREADY}, 32'd0);
    chk("s1_wait_hresp",  {31'd0, bus.HRESP},  32'd0);
    step();
    bus.S_HREADYOUT = 4'b1111;
    #1;
    chk("s1_hready", {31'd0, bus.HREADY}, 32'd1);
    chk("s1_hrdata", bus.HRDATA, 32'hDEAD_BEEF);
    chk("s1_hresp",  {31'd0, bus.HRESP}, 32'd0);

    // Unmapped NONSEQ -> ERR1, ERR2, then OKAY
    step();
    drive(32'h6000_0000, HTRANS_NONSEQ);
    chk("um_hsel", {28'd0, bus.S_HSEL}, 32'b0000);
    step();
    drive(32'h0, HTRANS_IDLE);
    chk("um_e1_hready", {31'd0, bus.HREADY}, 32'd0);
    chk("um_e1_hresp",  {31'd0, bus.HRESP},  32'd1);
    chk("um_e1_hrdata", bus.HRDATA, 32'h0);
    step();
    #1;
    chk("um_e2_hready", {31'd0, bus.HREADY}, 32'd1);
    chk("um_e2_hresp",  {31'd0, bus.HRESP},  32'd1);
    step();
    #1;
    chk("um_idle_hready", {31'd0, bus.HREADY}, 32'd1);
    chk("um_idle_hresp",  {31'd0, bus.HRESP},  32'd0);

    // Unmapped then slave0 back-to-back
    drive(32'h6000_0000, HTRANS_NONSEQ);
    step();
    drive(32'h0000_0004, HTRANS_NONSEQ);
    chk("bb_e1_hready", {31'd0, bus.HREADY}, 32'd0);
    chk("bb_e1_hresp",  {31'd0, bus.HRESP},  32'd1);
    step();
    #1;
    chk("bb_e2_hready", {31'd0, bus.HREADY}, 32'd1);
    chk("bb_e2_hresp",  {31'd0, bus.HRESP},  32'd1);
    step();
    drive(32'h0, HTRANS_IDLE);
    chk("bb_s0_hready", {31'd0, bus.HREADY}, 32'd1);
    chk("bb_s0_hresp",  {31'd0, bus.HRESP},  32'd0);
    chk("bb_s0_hrdata", bus.HRDATA, 32'h1111_1111);
    step();

    // Two unmapped NONSEQs: ERR2 goes straight back to ERR1
    drive(32'h6000_0000, HTRANS_NONSEQ);
    step();
    step();
    #1;
    chk("uu_e2_hresp", {31'd0, bus.HRESP}, 32'd1);
    step();
    drive(32'h0, HTRANS_IDLE);
    chk("uu_e1_hready", {31'd0, bus.HREADY}, 32'd0);
    chk("uu_e1_hresp",  {31'd0, bus.HRESP},  32'd1);
    step();
    step();

    // IDLE to unmapped space: zero-wait OKAY
    drive(32'h7000_0000, HTRANS_IDLE);
    step();
    #1;
    chk("idl_hready", {31'd0, bus.HREADY}, 32'd1);
    chk("idl_hresp",  {31'd0, bus.HRESP},  32'd0);
    chk("idl_hrdata", bus.HRDATA, 32'h0);

    // Reset asserted during ERR1
    drive(32'h6000_0000, HTRANS_NONSEQ);
    step();
    drive(32'h0, HTRANS_IDLE);
    chk("re_e1_hready", {31'd0, bus.HREADY}, 32'd0);
    HRESET = 1'b1;
    #1;
    chk("re_async_hready", {31'd0, bus.HREADY}, 32'd1);
    chk("re_async_hresp",  {31'd0, bus.HRESP},  32'd0);
    #1;
    HRESET = 1'b0;
    step();
    #1;
    chk("re_after_hready", {31'd0, bus.HREADY}, 32'd1);
    chk("re_after_hresp",  {31'd0, bus.HRESP},  32'd0);

    // Slave2 hangs
    bus.S_HREADYOUT = 4'b1011;
    drive(32'h4000_0000, HTRANS_NONSEQ);
    step();
    drive(32'h0, HTRANS_IDLE);
    chk("to_stall0_hready", {31'd0, bus.HREADY}, 32'd0);
    chk("to_stall0_hresp",  {31'd0, bus.HRESP},  32'd0);
    repeat (7) step();
    #1;
    chk("to_stall7_hready", {31'd0, bus.HREADY}, 32'd0);
    chk("to_stall7_hresp",  {31'd0, bus.HRESP},  32'd0);
    chk("to_stall7_tmask",  {28'd0, TIMEOUT_MASK}, 32'd0);
    step();
    #1;
`ifdef AHBL_TIMEOUT_EN
    chk("to_e1_hready", {31'd0, bus.HREADY}, 32'd0);
    chk("to_e1_hresp",  {31'd0, bus.HRESP},  32'd1);
    chk("to_e1_tmask",  {28'd0, TIMEOUT_MASK}, 32'b0100);
    step();
    #1;
    chk("to_e2_hready", {31'd0, bus.HREADY}, 32'd1);
    chk("to_e2_hresp",  {31'd0, bus.HRESP},  32'd1);
    step();
    bus.S_HREADYOUT = 4'b1111;
    drive(32'h4000_0000, HTRANS_NONSEQ);
    chk("mk_hsel", {28'd0, bus.S_HSEL}, 32'b0000);
    step();
    drive(32'h0, HTRANS_IDLE);
    chk("mk_e1_hready", {31'd0, bus.HREADY}, 32'd0);
    chk("mk_e1_hresp",  {31'd0, bus.HRESP},  32'd1);
    step();
    step();
    #1;
    chk("mk_tmask_sticky", {28'd0, TIMEOUT_MASK}, 32'b0100);
`else
    chk("nt_stall8_hready", {31'd0, bus.HREADY}, 32'd0);
    chk("nt_stall8_hresp",  {31'd0, bus.HRESP},  32'd0);
    repeat (10) step();
    #1;
    chk("nt_stall18_hready", {31'd0, bus.HREADY}, 32'd0);
    chk("nt_tmask",          {28'd0, TIMEOUT_MASK}, 32'd0);
    bus.S_HREADYOUT = 4'b1111;
    #1;
    chk("nt_s2_hrdata", bus.HRDATA, 32'h2222_2222);
    chk("nt_s2_hready", {31'd0, bus.HREADY}, 32'd1);
    step();
    drive(32'h4000_0000, HTRANS_NONSEQ);
    chk("nt_hsel", {28'd0, bus.S_HSEL}, 32'b0100);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
